// File: rtl/pad_seq_ctrl.sv
// Per-layer conv-input control-beat sequencer; PAD_SEQ_STALL_CNT_EN adds a saturating stall counter.
// Config accepted at T gives its config beat at T+1; beats hold stable while m_ready is low, 1 beat/cycle otherwise.
module pad_seq_ctrl #(
    parameter int KW_MAX      = 7,
    parameter int SW_MAX      = 4,
    parameter int BITS_KW2    = $clog2(KW_MAX / 2 + 1),
    parameter int BITS_SW     = $clog2(SW_MAX),
    parameter int BITS_CIN    = 10,
    parameter int BITS_COLS   = 10,
    parameter int BITS_BLOCKS = 10
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   aclken,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [BITS_KW2-1:0]    cfg_kw2,
    input  logic [BITS_SW-1:0]     cfg_sw_1,
    input  logic [BITS_CIN-1:0]    cfg_cin_1,
    input  logic [BITS_COLS-1:0]   cfg_cols_1,
    input  logic [BITS_BLOCKS-1:0] cfg_blocks_1,
    output logic                   cfg_err,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [BITS_KW2-1:0]    m_kw2,
    output logic [BITS_SW-1:0]     m_sw_1,
    output logic                   m_is_config,
    output logic                   m_is_cin_last,
    output logic                   m_is_cols_1_k2,
    output logic                   m_is_col_valid,
    output logic                   m_last,
`ifdef PAD_SEQ_STALL_CNT_EN
    output logic [31:0]            stall_cnt,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_RUN} state_t;

    state_t                 state_q, state_d;
    logic [BITS_KW2-1:0]    kw2_q, kw2_d;
    logic [BITS_SW-1:0]     sw_1_q, sw_1_d;
    logic [BITS_CIN-1:0]    cin_1_q, cin_1_d;
    logic [BITS_COLS-1:0]   cols_1_q, cols_1_d;
    logic [BITS_BLOCKS-1:0] blocks_1_q, blocks_1_d;
    logic [BITS_CIN-1:0]    cin_q, cin_d;
    logic [BITS_COLS-1:0]   col_q, col_d;
    logic [BITS_SW-1:0]     phase_q, phase_d;
    logic [BITS_BLOCKS-1:0] blk_q, blk_d;
    logic                   m_valid_q, m_valid_d;
    logic                   is_config_q, is_config_d;
    logic                   cin_last_q, cin_last_d;
    logic                   cols_k2_q, cols_k2_d;
    logic                   col_valid_q, col_valid_d;
    logic                   last_q, last_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   cfg_bad;
    logic                   cfg_take;
    logic                   beat_acc;

    assign cfg_bad  = (cfg_cols_1 < {{(BITS_COLS - BITS_KW2){1'b0}}, cfg_kw2}) ||
                      (32'(cfg_sw_1) >= 32'(SW_MAX));
    assign cfg_take = (state_q == ST_IDLE) && cfg_valid && !cfg_bad;
    assign beat_acc = m_valid_q && m_ready;

    always_comb begin
        state_d     = state_q;
        kw2_d       = kw2_q;
        sw_1_d      = sw_1_q;
        cin_1_d     = cin_1_q;
        cols_1_d    = cols_1_q;
        blocks_1_d  = blocks_1_q;
        cin_d       = cin_q;
        col_d       = col_q;
        phase_d     = phase_q;
        blk_d       = blk_q;
        cfg_err_d   = 1'b0;
        cin_last_d  = 1'b0;
        cols_k2_d   = 1'b0;
        col_valid_d = 1'b0;
        last_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        kw2_d      = cfg_kw2;
                        sw_1_d     = cfg_sw_1;
                        cin_1_d    = cfg_cin_1;
                        cols_1_d   = cfg_cols_1;
                        blocks_1_d = cfg_blocks_1;
                        cin_d      = '0;
                        col_d      = '0;
                        phase_d    = '0;
                        blk_d      = '0;
                        state_d    = ST_CFG;
                    end
                end
            end
            ST_CFG: begin
                if (beat_acc) begin
                    cin_d   = '0;
                    col_d   = '0;
                    phase_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat_acc) begin
                    if (cin_q == cin_1_q) begin
                        cin_d = '0;
                        if (col_q == cols_1_q) begin
                            col_d   = '0;
                            phase_d = '0;
                            if (blk_q == blocks_1_q) begin
                                blk_d   = '0;
                                state_d = ST_IDLE;
                            end else begin
                                blk_d   = blk_q + 1'b1;
                                state_d = ST_CFG;
                            end
                        end else begin
                            col_d   = col_q + 1'b1;
                            phase_d = (phase_q == sw_1_q) ? '0 : phase_q + 1'b1;
                        end
                    end else begin
                        cin_d = cin_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flags describe the beat presented after this edge, so they come from the next-state counters.
        m_valid_d   = (state_d != ST_IDLE);
        is_config_d = (state_d == ST_CFG);
        if (state_d == ST_RUN) begin
            cin_last_d  = (cin_d == cin_1_d);
            cols_k2_d   = (col_d == cols_1_d - {{(BITS_COLS - BITS_KW2){1'b0}}, kw2_d});
            col_valid_d = (phase_d == '0);
            last_d      = cin_last_d && (col_d == cols_1_d) && (blk_d == blocks_1_d);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            kw2_q       <= '0;
            sw_1_q      <= '0;
            cin_1_q     <= '0;
            cols_1_q    <= '0;
            blocks_1_q  <= '0;
            cin_q       <= '0;
            col_q       <= '0;
            phase_q     <= '0;
            blk_q       <= '0;
            m_valid_q   <= 1'b0;
            is_config_q <= 1'b0;
            cin_last_q  <= 1'b0;
            cols_k2_q   <= 1'b0;
            col_valid_q <= 1'b0;
            last_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else if (aclken) begin
            state_q     <= state_d;
            kw2_q       <= kw2_d;
            sw_1_q      <= sw_1_d;
            cin_1_q     <= cin_1_d;
            cols_1_q    <= cols_1_d;
            blocks_1_q  <= blocks_1_d;
            cin_q       <= cin_d;
            col_q       <= col_d;
            phase_q     <= phase_d;
            blk_q       <= blk_d;
            m_valid_q   <= m_valid_d;
            is_config_q <= is_config_d;
            cin_last_q  <= cin_last_d;
            cols_k2_q   <= cols_k2_d;
            col_valid_q <= col_valid_d;
            last_q      <= last_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef PAD_SEQ_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cfg_take) begin
            stall_cnt_d = '0;
        end else if (m_valid_q && !m_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stall_cnt_q <= '0;
        end else if (aclken) begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_cfg_take;
    assign unused_cfg_take = cfg_take;
`endif

    assign cfg_ready      = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign cfg_err        = cfg_err_q;
    assign m_valid        = m_valid_q;
    assign m_kw2          = kw2_q;
    assign m_sw_1         = sw_1_q;
    assign m_is_config    = is_config_q;
    assign m_is_cin_last  = cin_last_q;
    assign m_is_cols_1_k2 = cols_k2_q;
    assign m_is_col_valid = col_valid_q;
    assign m_last         = last_q;

endmodule

// File: tb/tb_pad_seq_ctrl.sv
// Directed bench for pad_seq_ctrl: beat sequences, stalls, clock-enable gaps, config errors, async reset.
module tb_pad_seq_ctrl;

    logic        aclk = 1'b0;
    logic        areset;
    logic        aclken;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_kw2;
    logic [1:0]  cfg_sw_1;
    logic [9:0]  cfg_cin_1;
    logic [9:0]  cfg_cols_1;
    logic [9:0]  cfg_blocks_1;
    logic        cfg_err;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_kw2;
    logic [1:0]  m_sw_1;
    logic        m_is_config;
    logic        m_is_cin_last;
    logic        m_is_cols_1_k2;
    logic        m_is_col_valid;
    logic        m_last;
    logic        busy;
`ifdef PAD_SEQ_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 aclk = ~aclk;

    pad_seq_ctrl dut (
`ifdef PAD_SEQ_STALL_CNT_EN
        .stall_cnt      (stall_cnt),
`endif
        .aclk           (aclk),
        .areset         (areset),
        .aclken         (aclken),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_kw2        (cfg_kw2),
        .cfg_sw_1       (cfg_sw_1),
        .cfg_cin_1      (cfg_cin_1),
        .cfg_cols_1     (cfg_cols_1),
        .cfg_blocks_1   (cfg_blocks_1),
        .cfg_err        (cfg_err),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_kw2          (m_kw2),
        .m_sw_1         (m_sw_1),
        .m_is_config    (m_is_config),
        .m_is_cin_last  (m_is_cin_last),
        .m_is_cols_1_k2 (m_is_cols_1_k2),
        .m_is_col_valid (m_is_col_valid),
        .m_last         (m_last),
        .busy           (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int stalls;
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat image: {valid, kw2, sw_1, is_config, cin_last, cols_1_k2, col_valid, last}
    function automatic logic [9:0] mk(input logic [1:0] k, input logic [1:0] s, input logic [4:0] f);
        return {1'b1, k, s, f};
    endfunction

    function automatic logic [9:0] snap();
        return {m_valid, m_kw2, m_sw_1, m_is_config, m_is_cin_last,
                m_is_cols_1_k2, m_is_col_valid, m_last};
    endfunction

    task automatic gen_exp(input int kw2, input int sw1, input int cin1, input int cols1, input int b1);
        logic [4:0] f;
        for (int b = 0; b <= b1; b++) begin
            exp_q.push_back(mk(2'(kw2), 2'(sw1), 5'b10000));
            for (int c = 0; c <= cols1; c++) begin
                for (int i = 0; i <= cin1; i++) begin
                    f[4] = 1'b0;
                    f[3] = (i == cin1);
                    f[2] = (c == cols1 - kw2);
                    f[1] = ((c % (sw1 + 1)) == 0);
                    f[0] = (i == cin1) && (c == cols1) && (b == b1);
                    exp_q.push_back(mk(2'(kw2), 2'(sw1), f));
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the config edge.
    task automatic send_cfg(input int kw2, input int sw1, input int cin1, input int cols1, input int b1);
        cfg_kw2      = 2'(kw2);
        cfg_sw_1     = 2'(sw1);
        cfg_cin_1    = 10'(cin1);
        cfg_cols_1   = 10'(cols1);
        cfg_blocks_1 = 10'(b1);
        cfg_valid    = 1'b1;
        @(negedge aclk);
        cfg_valid    = 1'b0;
    endtask

    // Collects n accepted beats starting at the current negedge, checking that
    // outputs hold across every stalled or clock-disabled cycle.
    task automatic collect(input int n, input bit rnd, input int gap_at);
        logic [9:0] cur;
        logic [9:0] prev = '0;
        bit         hold_chk = 1'b0;
        bit         rdy;
        bit         en;
        int         gap_left = 5;
        int         cyc = 0;
        got_q.delete();
        stalls = 0;
        while (1) begin
            cur = snap();
            if (hold_chk) chk("hold", 32'(cur), 32'(prev));
            if (got_q.size() == n) break;
            if (cyc >= 1000) begin
                chk("timeout_beats", 32'(got_q.size()), 32'(n));
                break;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            en  = 1'b1;
            if (gap_at >= 0 && got_q.size() == gap_at && gap_left > 0) begin
                en = 1'b0;
                gap_left--;
            end
            aclken  = en;
            m_ready = rdy;
            if (m_valid && rdy && en) begin
                got_q.push_back(cur);
                hold_chk = 1'b0;
            end else if (m_valid) begin
                hold_chk = 1'b1;
                prev     = cur;
                if (en) stalls++;
            end else begin
                hold_chk = 1'b0;
            end
            @(negedge aclk);
            cyc++;
        end
        m_ready = 1'b0;
        aclken  = 1'b1;
    endtask

    task automatic cmp_seq(input string tag);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    initial begin
        areset = 1'b1; aclken = 1'b1; cfg_valid = 1'b0; m_ready = 1'b0;
        cfg_kw2 = '0; cfg_sw_1 = '0; cfg_cin_1 = '0; cfg_cols_1 = '0; cfg_blocks_1 = '0;
        repeat (3) @(negedge aclk);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_outs", 32'(snap()), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
`ifdef PAD_SEQ_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        areset = 1'b0;
        @(negedge aclk);

        // Layer 1: single block, hand-computed flag sequence.
        send_cfg(1, 0, 1, 3, 0);
        chk("l1_latency", 32'(m_valid), 32'd1);
        chk("l1_cfg_ready", 32'(cfg_ready), 32'd0);
        exp_q = '{mk(2'd1, 2'd0, 5'b10000), mk(2'd1, 2'd0, 5'b00010), mk(2'd1, 2'd0, 5'b01010),
                  mk(2'd1, 2'd0, 5'b00010), mk(2'd1, 2'd0, 5'b01010), mk(2'd1, 2'd0, 5'b00110),
                  mk(2'd1, 2'd0, 5'b01110), mk(2'd1, 2'd0, 5'b00010), mk(2'd1, 2'd0, 5'b01011)};
        collect(9, 1'b0, -1);
        cmp_seq("l1");
        chk("l1_busy_end", 32'(busy), 32'd0);

        // Layer 2: two blocks, stride 2, single cin.
        send_cfg(2, 1, 0, 4, 1);
        exp_q = '{mk(2'd2, 2'd1, 5'b10000), mk(2'd2, 2'd1, 5'b01010), mk(2'd2, 2'd1, 5'b01000),
                  mk(2'd2, 2'd1, 5'b01110), mk(2'd2, 2'd1, 5'b01000), mk(2'd2, 2'd1, 5'b01010),
                  mk(2'd2, 2'd1, 5'b10000), mk(2'd2, 2'd1, 5'b01010), mk(2'd2, 2'd1, 5'b01000),
                  mk(2'd2, 2'd1, 5'b01110), mk(2'd2, 2'd1, 5'b01000), mk(2'd2, 2'd1, 5'b01011)};
        collect(12, 1'b0, -1);
        cmp_seq("l2");
        chk("l2_valid_end", 32'(m_valid), 32'd0);

        // Rejected config, then a valid one.
        send_cfg(3, 0, 0, 2, 0);
        chk("err_pulse", 32'(cfg_err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge aclk);
        chk("err_pulse_end", 32'(cfg_err), 32'd0);
        chk("err_valid", 32'(m_valid), 32'd0);
        send_cfg(2, 1, 0, 4, 1);
        chk("err_next_busy", 32'(busy), 32'd1);
        gen_exp(2, 1, 0, 4, 1);
        collect(12, 1'b0, -1);
        cmp_seq("after_err");

        // Layer 3: cin_1=2, full ready then random backpressure.
        send_cfg(1, 1, 2, 2, 1);
        gen_exp(1, 1, 2, 2, 1);
        collect(20, 1'b0, -1);
        cmp_seq("l3_full");
        send_cfg(1, 1, 2, 2, 1);
        gen_exp(1, 1, 2, 2, 1);
        collect(20, 1'b1, -1);
        cmp_seq("l3_rnd");
`ifdef PAD_SEQ_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(stalls));
`endif

        // Clock-enable gap of 5 cycles after the fourth beat.
        send_cfg(1, 0, 1, 3, 0);
        gen_exp(1, 0, 1, 3, 0);
        collect(9, 1'b0, 4);
        cmp_seq("gap");

        // Async reset while presenting the col-2 beat.
        send_cfg(1, 0, 1, 3, 0);
        collect(5, 1'b0, -1);
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        chk("pre_rst_flags", 32'(snap()), 32'(mk(2'd1, 2'd0, 5'b00110)));
        #2 areset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        send_cfg(1, 0, 1, 3, 0);
        gen_exp(1, 0, 1, 3, 0);
        collect(9, 1'b0, -1);
        cmp_seq("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pad_seq_ctrl.md
Name: pad_seq_ctrl

Overview:
- Sequences the convolution input stream that feeds the padding/masking stage.
- Per layer, accepts one configuration: kernel half-width, stride−1, cin−1, cols−1, blocks−1.
- Emits one control beat per (block, column, cin) carrying the TUSER-style flags the pad stage consumes: is_config, is_cin_last, is_cols_1_k2, is_col_valid, kw2, sw_1.
- Sits between the layer config register bank and the conv-input TUSER packer.

Parameters:
KW_MAX, 7, max odd kernel width; KW2 width BITS_KW2 = clog2(KW_MAX/2+1)
SW_MAX, 4, max stride; BITS_SW = clog2(SW_MAX)
BITS_CIN, 10, width of cin−1 counter
BITS_COLS, 10, width of cols−1 counter
BITS_BLOCKS, 10, width of blocks−1 counter

Ports:
aclk  in  1  clock
areset  in  1  asynchronous, active-high reset
aclken  in  1  global clock enable; all state frozen when low
cfg_valid  in  1  config handshake valid
cfg_ready  out  1  high only in IDLE
cfg_kw2  in  BITS_KW2  kernel width / 2
cfg_sw_1  in  BITS_SW  stride − 1
cfg_cin_1  in  BITS_CIN  input channels − 1
cfg_cols_1  in  BITS_COLS  image columns − 1
cfg_blocks_1  in  BITS_BLOCKS  row blocks − 1
cfg_err  out  1  one-cycle pulse on rejected config
m_valid  out  1  control beat valid
m_ready  in  1  downstream ready
m_kw2  out  BITS_KW2  latched kw2
m_sw_1  out  BITS_SW  latched sw_1
m_is_config  out  1  config beat, first beat of each block
m_is_cin_last  out  1  last cin of current column
m_is_cols_1_k2  out  1  column == cols_1 − kw2
m_is_col_valid  out  1  column on stride grid
m_last  out  1  final beat of layer
busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - State IDLE.
  - All counters 0.
  - m_valid, m_is_*, m_last, cfg_err, busy = 0.
  - m_kw2, m_sw_1 = 0.
  - cfg_ready = 1.
- All registers update only when aclken=1. Reset overrides aclken.
- FSM states: IDLE → CFG → RUN → IDLE.
  - IDLE: when cfg_valid & cfg_ready:
    - If cfg_cols_1 < cfg_kw2 or cfg_sw_1 ≥ SW_MAX: pulse cfg_err, stay IDLE.
    - Otherwise latch all cfg fields and go to CFG.
  - CFG: present a config beat: m_is_config=1, other flags 0, m_kw2/m_sw_1 valid. On m_ready, go to RUN with cin=col=phase=0.
  - RUN: one beat per cin, innermost. Loop order: cin inner, col middle, block outer.
- Flags on each RUN beat, all registered:
  - is_cin_last = (cin == cin_1).
  - is_cols_1_k2 = (col == cols_1 − kw2). With kw2=0 this is the last column.
  - is_col_valid = (phase == 0). phase counts 0..sw_1 per column, resets at col 0 of each block, wraps sw_1 → 0.
  - m_last = cin_last & (col == cols_1) & (block == blocks_1).
- Counter advance on each accepted beat (m_valid & m_ready):
  - cin increments; it wraps to 0 on cin_1.
  - On cin wrap, col and phase advance.
  - On col wrap at cols_1: block increments and the FSM returns to CFG, giving one config beat per block.
  - After the m_last beat is accepted: go to IDLE, m_valid=0.
- Handshake:
  - m_valid & !m_ready holds every m_* output stable.
  - m_valid never drops without acceptance, except on reset.
  - Throughput: 1 beat per cycle when m_ready=1 and aclken=1.
- Latency: config accepted at cycle T → config beat valid at T+1.
- Beats per layer: (blocks_1+1) × (1 + (cols_1+1)(cin_1+1)).
- Degenerate values:
  - cin_1=0: every RUN beat has is_cin_last.
  - cols_1=kw2: is_cols_1_k2 on col 0.
  - sw_1=0: is_col_valid always 1.
- Reset mid-RUN: returns to IDLE immediately and drops m_valid asynchronously.

Optional Feature:
- Macro PAD_SEQ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, 32 bits.
  - Counts cycles with aclken & m_valid & !m_ready.
  - Saturates at all-ones.
  - Cleared on config accept and on reset.
- When undefined: no port and no counter logic.

Test Plan:
- kw2=1, sw_1=0, cin_1=1, cols_1=3, blocks_1=0, m_ready=1 → 9 beats back to back:
  - beat 0 is_config.
  - is_cin_last on beats 2,4,6,8.
  - is_cols_1_k2 on beats 5,6 (col 2).
  - m_last on beat 8; busy falls next cycle.
- kw2=2, sw_1=1, cin_1=0, cols_1=4, blocks_1=1 → per block 1 config + 5 beats; is_col_valid pattern 1,0,1,0,1; is_cols_1_k2 on col 2; 12 beats total; m_last only on beat 11.
- m_ready toggled pseudo-randomly with cin_1=2 → outputs stable while stalled; beat sequence identical to the m_ready=1 run; with PAD_SEQ_STALL_CNT_EN, stall_cnt equals the count of stall cycles.
- cfg_kw2=3, cfg_cols_1=2 → cfg_err pulses one cycle; busy stays 0; a following valid config is accepted.
- aclken held low for 5 cycles mid-RUN → no counter or flag change; sequence resumes exactly.
- areset asserted mid-RUN at col 2 → m_valid=0 immediately, state IDLE, cfg_ready=1; a new config restarts from a config beat.
